reg_scoreboard: RTL and testbench

//   Tracks in-flight register writes between decode and the register file write port.

---
 rtl/reg_scoreboard_if.sv | 36 +++
 rtl/reg_scoreboard.sv | 84 ++++++++
 tb/tb_reg_scoreboard.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Decode-side bus of the register scoreboard: issue request, writeback/kill retire ports and status.
// The master drives decode and retire traffic; the slave is the scoreboard itself.
interface reg_scoreboard_if #(
    parameter int NREG   = 15,
    parameter int PERF_W = 16
);
    logic              issueValid;
    logic              src1Use;
    logic [3:0]        src1A;
    logic              src2Use;
    logic [3:0]        src2A;
    logic              src3Use;
    logic [3:0]        src3A;
    logic              dstUse;
    logic [3:0]        dstA;
    logic              issueReady;
    logic              wbValid;
    logic [3:0]        wbA;
    logic              killValid;
    logic [3:0]        killA;
    logic [NREG-1:0]   pending;
    logic [PERF_W-1:0] stallCnt;
    logic              err;

    modport master (
        output issueValid, src1Use, src1A, src2Use, src2A, src3Use, src3A,
               dstUse, dstA, wbValid, wbA, killValid, killA,
        input  issueReady, pending, stallCnt, err
    );

    modport slave (
        input  issueValid, src1Use, src1A, src2Use, src2A, src3Use, src3A,
               dstUse, dstA, wbValid, wbA, killValid, killA,
        output issueReady, pending, stallCnt, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per register and holds issue on RAW hazards
// or when a destination counter is already full. Register 15 (PC) is never tracked.
module reg_scoreboard #(
    parameter int NREG   = 15,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    reg_scoreboard_if.slave bus
);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0]  r_count [NREG];
    logic [NREG-1:0]   r_pending;
    logic [PERF_W-1:0] r_stall;
    logic              r_err;

    logic [CNT_W-1:0]  w_next [NREG];
    logic              w_hazard;
    logic              w_ready;
    logic              w_fire;
    logic              w_underflow;

    // A source is blocked while its count is nonzero, unless the last outstanding write lands
    // this very cycle (the register file writes on the falling edge). Kill never unblocks.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            logic wbHit;
            logic busy;
            wbHit = bus.wbValid && (bus.wbA == 4'(i));
            busy  = (r_count[i] != '0) && !((r_count[i] == CMAX'(1)) && wbHit);
            if (bus.src1Use && (bus.src1A == 4'(i)) && busy) w_hazard = 1'b1;
            if (bus.src2Use && (bus.src2A == 4'(i)) && busy) w_hazard = 1'b1;
            if (bus.src3Use && (bus.src3A == 4'(i)) && busy) w_hazard = 1'b1;
            if (bus.dstUse && (bus.dstA == 4'(i)) && (r_count[i] == CMAX)) w_hazard = 1'b1;
        end
    end

    assign w_ready = i_rst_n && !w_hazard;
    assign w_fire  = bus.issueValid && w_ready;

    always_comb begin
        w_underflow = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            logic [CNT_W:0] sum;
            logic [1:0]     dec;
            sum = {1'b0, r_count[i]}
                + (CNT_W+1)'(w_fire && bus.dstUse && (bus.dstA == 4'(i)));
            dec = 2'(bus.wbValid && (bus.wbA == 4'(i)))
                + 2'(bus.killValid && (bus.killA == 4'(i)));
            if ((CNT_W+1)'(dec) > sum) begin
                w_next[i]   = '0;
                w_underflow = 1'b1;
            end else begin
                w_next[i] = CNT_W'(sum - (CNT_W+1)'(dec));
            end
        end
    end

    // Stall counter saturates rather than wrapping so long stalls stay visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) r_count[i] <= '0;
            r_pending <= '0;
            r_stall   <= '0;
            r_err     <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_count[i]   <= w_next[i];
                r_pending[i] <= (w_next[i] != '0);
            end
            if (w_underflow) r_err <= 1'b1;
            if (bus.issueValid && !w_ready && (r_stall != '1))
                r_stall <= r_stall + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.issueReady = w_ready;
    assign bus.pending    = r_pending;
    assign bus.stallCnt   = r_stall;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: reset, RAW stall/bypass, R15, saturation,
// simultaneous issue/WB/kill and sticky underflow error.
module tb_reg_scoreboard;
    logic i_clk;
    logic i_rst_n;
    int   passCount;
    int   checkCount;

    reg_scoreboard_if #(.NREG(15), .PERF_W(16)) bus ();

    reg_scoreboard #(.NREG(15), .CNT_W(2), .PERF_W(16)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic iv, input logic s1u, input logic [3:0] s1a,
                                 input logic s2u, input logic [3:0] s2a,
                                 input logic s3u, input logic [3:0] s3a,
                                 input logic du, input logic [3:0] da,
                                 input logic wv, input logic [3:0] wa,
                                 input logic kv, input logic [3:0] ka);
        bus.issueValid = iv;
        bus.src1Use = s1u; bus.src1A = s1a;
        bus.src2Use = s2u; bus.src2A = s2a;
        bus.src3Use = s3u; bus.src3A = s3a;
        bus.dstUse  = du;  bus.dstA  = da;
        bus.wbValid = wv;  bus.wbA   = wa;
        bus.killValid = kv; bus.killA = ka;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;

        // Reset held with random traffic on every input
        i_rst_n = 1'b0;
        applyStimulus(1, 1, 4'($urandom_range(0, 15)), 1, 4'($urandom_range(0, 15)),
                      1, 4'($urandom_range(0, 15)), 1, 4'($urandom_range(0, 15)),
                      1, 4'($urandom_range(0, 15)), 1, 4'($urandom_range(0, 15)));
        #1;
        checkOutput("rst_ready", 32'(bus.issueReady), 32'd0);
        checkOutput("rst_pending", 32'(bus.pending), 32'd0);
        checkOutput("rst_stall", 32'(bus.stallCnt), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        tick();
        tick();
        checkOutput("rst_stall_hold", 32'(bus.stallCnt), 32'd0);
        checkOutput("rst_pending_hold", 32'(bus.pending), 32'd0);
        idle();
        i_rst_n = 1'b1;
        tick();

        // RAW on R3
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        checkOutput("raw_issue_ready", 32'(bus.issueReady), 32'd1);
        tick();
        checkOutput("raw_pending3", 32'(bus.pending), 32'h0008);
        applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_blocked", 32'(bus.issueReady), 32'd0);
        tick();
        checkOutput("raw_stall1", 32'(bus.stallCnt), 32'd1);
        tick();
        checkOutput("raw_stall2", 32'(bus.stallCnt), 32'd2);
        applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        checkOutput("raw_wb_bypass", 32'(bus.issueReady), 32'd1);
        tick();
        checkOutput("raw_pending_clear", 32'(bus.pending), 32'd0);
        checkOutput("raw_stall_hold", 32'(bus.stallCnt), 32'd2);

        // R15 is never tracked
        applyStimulus(1, 1, 15, 0, 0, 0, 0, 1, 15, 1, 15, 0, 0);
        checkOutput("r15_ready", 32'(bus.issueReady), 32'd1);
        tick();
        checkOutput("r15_pending", 32'(bus.pending), 32'd0);
        checkOutput("r15_err", 32'(bus.err), 32'd0);

        // Saturation on R5
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("sat_third_ready", 32'(bus.issueReady), 32'd1);
        tick();
        checkOutput("sat_pending5", 32'(bus.pending), 32'h0020);
        checkOutput("sat_full_block", 32'(bus.issueReady), 32'd0);
        tick();
        checkOutput("sat_stall3", 32'(bus.stallCnt), 32'd3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        checkOutput("sat_after_wb_ready", 32'(bus.issueReady), 32'd1);
        tick();
        checkOutput("sat_refull_block", 32'(bus.issueReady), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        tick();
        tick();
        checkOutput("sat_drain_partial", 32'(bus.pending), 32'h0020);
        tick();
        checkOutput("sat_drained", 32'(bus.pending), 32'd0);
        checkOutput("sat_no_err", 32'(bus.err), 32'd0);

        // Simultaneous issue / writeback / kill on R7
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0);
        checkOutput("sim_issue_wb_ready", 32'(bus.issueReady), 32'd1);
        tick();
        checkOutput("sim_pending7", 32'(bus.pending), 32'h0080);
        applyStimulus(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 7);
        checkOutput("sim_kill_no_bypass", 32'(bus.issueReady), 32'd0);
        applyStimulus(0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0);
        checkOutput("sim_src2_wb_bypass", 32'(bus.issueReady), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 7, 0, 0, 1, 7, 0, 0);
        checkOutput("sim_cnt2_no_bypass", 32'(bus.issueReady), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7);
        tick();
        checkOutput("sim_kill_wb_clear", 32'(bus.pending), 32'd0);
        checkOutput("sim_no_err", 32'(bus.err), 32'd0);
        checkOutput("sim_stall_total", 32'(bus.stallCnt), 32'd3);

        // Underflow error on R9
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        tick();
        checkOutput("err_set", 32'(bus.err), 32'd1);
        checkOutput("err_pending_zero", 32'(bus.pending), 32'd0);
        idle();
        tick();
        tick();
        checkOutput("err_sticky", 32'(bus.err), 32'd1);
        i_rst_n = 1'b0;
        #1;
        checkOutput("err_cleared_by_reset", 32'(bus.err), 32'd0);
        checkOutput("reset_ready_low", 32'(bus.issueReady), 32'd0);
        checkOutput("reset_stall_clear", 32'(bus.stallCnt), 32'd0);
        i_rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
